// File: rtl/periph_bus_pkg.sv
// Shared constants for the peripheral bus fabric: FSM state codes, the
// bus-error read pattern and the default slave address map.
package periph_bus_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WAIT_RD = 1'b1;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  // Slave 0 occupies the leftmost field of each flat vector
  localparam logic [43:0] DEF_SLV_BASE = {11'h000, 11'h402, 11'h404, 11'h408};
  localparam logic [43:0] DEF_SLV_MASK = {11'h400, 11'h7FE, 11'h7FC, 11'h7F8};

endpackage

// File: rtl/periph_addr_decoder.sv
// Combinational address decoder: base/mask compare per slave, lowest
// matching index wins and is returned both one-hot and encoded.
module periph_addr_decoder
  import periph_bus_pkg::*;
#(
  parameter int unsigned              NSLV     = 4,
  parameter int unsigned              ADDRW    = 11,
  parameter logic [NSLV*ADDRW-1:0]    SLV_BASE = DEF_SLV_BASE,
  parameter logic [NSLV*ADDRW-1:0]    SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned              IDXW     = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [ADDRW-1:0] addr,
  output logic             hit,
  output logic [NSLV-1:0]  sel,
  output logic [IDXW-1:0]  idx
);

  // Scan from the top so the lowest matching slave is written last
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if ((addr & SLV_MASK[(NSLV-1-k)*ADDRW +: ADDRW]) ==
          SLV_BASE[(NSLV-1-k)*ADDRW +: ADDRW]) begin
        hit = 1'b1;
        sel = NSLV'(1) << k;
        idx = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/periph_bus_fabric.sv
// Two-master (core, programmer) to NSLV-slave peripheral bus fabric.
// Define BUS_TIMEOUT_EN to enable the read-wait timeout counter.
module periph_bus_fabric
  import periph_bus_pkg::*;
#(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           NSLV     = 4,
  parameter int unsigned           ADDRW    = 11,
  parameter logic [NSLV*ADDRW-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NSLV*ADDRW-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned           TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rstB,
  input  logic [ADDRW-1:0]     m0_addr,
  input  logic [XLEN-1:0]      m0_wrData,
  input  logic                 m0_wrEn,
  input  logic                 m0_rdEn,
  output logic                 m0_ready,
  output logic [XLEN-1:0]      m0_rdData,
  output logic                 m0_rdValid,
  output logic                 m0_err,
  input  logic [ADDRW-1:0]     m1_addr,
  input  logic [XLEN-1:0]      m1_wrData,
  input  logic                 m1_wrEn,
  input  logic                 m1_rdEn,
  output logic                 m1_ready,
  output logic [XLEN-1:0]      m1_rdData,
  output logic                 m1_rdValid,
  output logic                 m1_err,
  output logic [ADDRW-1:0]     s_addr,
  output logic [XLEN-1:0]      s_wrData,
  output logic [NSLV-1:0]      s_wrEn,
  output logic [NSLV-1:0]      s_rdEn,
  input  logic [NSLV*XLEN-1:0] s_rdData,
  input  logic [NSLV-1:0]      s_outEn
);

  localparam int unsigned IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic [0:0]      state, state_n;
  logic [IDXW-1:0] lat_idx;
  logic            lat_mst;
  logic            lat_ld;

  logic            req0, req1, gnt1, req_wr, req_rd;
  logic [ADDRW-1:0] req_addr;
  logic            dec_hit;
  logic [NSLV-1:0] dec_sel;
  logic [IDXW-1:0] dec_idx;

  logic            lat_out_en;
  logic [XLEN-1:0] lat_rd_data;

  logic            rsp_vld, rsp_err, rsp_mst;
  logic [XLEN-1:0] rsp_data;

  // Programmer (m1) wins arbitration; the loser keeps its request up
  assign req0     = m0_wrEn | m0_rdEn;
  assign req1     = m1_wrEn | m1_rdEn;
  assign gnt1     = req1;
  assign req_wr   = gnt1 ? m1_wrEn : m0_wrEn;
  assign req_rd   = gnt1 ? m1_rdEn : m0_rdEn;
  assign req_addr = gnt1 ? m1_addr : m0_addr;
  assign s_addr   = req_addr;
  assign s_wrData = gnt1 ? m1_wrData : m0_wrData;

  periph_addr_decoder #(
    .NSLV     (NSLV),
    .ADDRW    (ADDRW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IDXW     (IDXW)
  ) u_dec (
    .addr (req_addr),
    .hit  (dec_hit),
    .sel  (dec_sel),
    .idx  (dec_idx)
  );

  // Response path of the slave captured when the read was issued
  always_comb begin
    lat_out_en  = 1'b0;
    lat_rd_data = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (lat_idx == IDXW'(k)) begin
        lat_out_en  = s_outEn[k];
        lat_rd_data = s_rdData[k*XLEN +: XLEN];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] to_cnt;
  logic            to_expired;

  assign to_expired = (to_cnt >= CNTW'(TIMEOUT - 1));

  // Held at zero outside WAIT_RD so every read starts a fresh count
  always_ff @(posedge clk) begin
    if (!rstB)
      to_cnt <= '0;
    else if (state != ST_WAIT_RD)
      to_cnt <= '0;
    else if (to_cnt != CNTW'(TIMEOUT))
      to_cnt <= to_cnt + CNTW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstB)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    s_wrEn   = '0;
    s_rdEn   = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    lat_ld   = 1'b0;
    rsp_vld  = 1'b0;
    rsp_err  = 1'b0;
    rsp_mst  = gnt1;
    rsp_data = '0;
    case (state)
      ST_IDLE: begin
        if (rstB && (req0 || req1)) begin
          m1_ready = gnt1;
          m0_ready = ~gnt1;
          if (req_wr) begin
            // A combined read+write keeps the write and flags the dropped read
            s_wrEn  = dec_hit ? dec_sel : '0;
            rsp_err = ~dec_hit | req_rd;
          end else if (dec_hit) begin
            s_rdEn  = dec_sel;
            lat_ld  = 1'b1;
            state_n = ST_WAIT_RD;
          end else begin
            rsp_vld = 1'b1;
            rsp_err = 1'b1;
          end
        end
      end
      ST_WAIT_RD: begin
        rsp_mst = lat_mst;
        if (lat_out_en) begin
          rsp_vld  = 1'b1;
          rsp_data = lat_rd_data;
          state_n  = ST_IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_expired) begin
          rsp_vld  = 1'b1;
          rsp_err  = 1'b1;
          rsp_data = XLEN'(BUS_ERR_DATA);
          state_n  = ST_IDLE;
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered responses: valid/err pulse, read data held until replaced
  always_ff @(posedge clk) begin
    if (!rstB) begin
      lat_idx    <= '0;
      lat_mst    <= 1'b0;
      m0_rdData  <= '0;
      m0_rdValid <= 1'b0;
      m0_err     <= 1'b0;
      m1_rdData  <= '0;
      m1_rdValid <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      if (lat_ld) begin
        lat_idx <= dec_idx;
        lat_mst <= gnt1;
      end
      m0_rdValid <= rsp_vld & ~rsp_mst;
      m0_err     <= rsp_err & ~rsp_mst;
      m1_rdValid <= rsp_vld & rsp_mst;
      m1_err     <= rsp_err & rsp_mst;
      if (rsp_vld && !rsp_mst)
        m0_rdData <= rsp_data;
      if (rsp_vld && rsp_mst)
        m1_rdData <= rsp_data;
    end
  end

endmodule

// File: doc/periph_bus_fabric.md
PERIPH_BUS_FABRIC -- requirements
Module: periph_bus_fabric

Interface
REQ-001 XLEN, default 32: data width.
REQ-002 NSLV, default 4: number of slaves.
REQ-003 ADDRW, default 11: address width.
REQ-004 SLV_BASE, default {11'h000,11'h402,11'h404,11'h408}: per-slave base address, flat NSLV*ADDRW vector.
REQ-005 SLV_MASK, default {11'h400,11'h7FE,11'h7FC,11'h7F8}: per-slave compare mask.
REQ-006 TIMEOUT, default 15: read-wait cycle limit.
REQ-007 clk  in  1  clock; rstB  in  1  reset, synchronous, active-low.
REQ-008 mN_addr  in  ADDRW, mN_wrData  in  XLEN, mN_wrEn  in  1, mN_rdEn  in  1: request from master N (N=0 core, N=1 programmer).
REQ-009 mN_ready  out  1  request accepted this cycle; mN_rdData  out  XLEN; mN_rdValid  out  1; mN_err  out  1.
REQ-010 s_addr  out  ADDRW, s_wrData  out  XLEN, s_wrEn  out  NSLV, s_rdEn  out  NSLV: slave request side.
REQ-011 s_rdData  in  NSLV*XLEN, s_outEn  in  NSLV: slave responses.

Function
REQ-012 Slave k SHALL be hit when (addr & SLV_MASK[k]) == SLV_BASE[k]; the lowest hit index wins.
REQ-013 States SHALL be IDLE and WAIT_RD.
REQ-014 In IDLE, m1 SHALL take priority over m0; mN_ready SHALL be 1 only for the granted requester; the losing master holds its request.
REQ-015 An accepted write SHALL drive s_addr/s_wrData and a one-hot s_wrEn combinationally in the same cycle; there is no response and the state stays IDLE.
REQ-016 An accepted write miss SHALL pulse mN_err for one cycle, registered, one cycle after acceptance.
REQ-017 An accepted read hit SHALL pulse one-hot s_rdEn in the acceptance cycle, latch the slave index and master, and go to WAIT_RD.
REQ-018 An accepted read miss SHALL stay in IDLE and return rdValid=1, err=1, rdData=0 on the next cycle.
REQ-019 In WAIT_RD, both mN_ready SHALL be 0.
REQ-020 In WAIT_RD, s_outEn of the latched slave SHALL produce rdData=s_rdData[k], rdValid=1 and err=0 for the latched master one cycle later, then return to IDLE.
REQ-021 s_outEn from any non-latched slave SHALL be ignored.
REQ-022 rdValid and err SHALL be single-cycle pulses; rdData SHALL hold its value until the next response.
REQ-023 rdEn and wrEn asserted together SHALL perform the write only; the read is dropped and err is pulsed.
REQ-024 Timeout: after TIMEOUT cycles in WAIT_RD without outEn, the fabric SHALL return rdValid=1, err=1, rdData=BUS_ERR_DATA and go to IDLE.
REQ-025 When outEn arrives in the same cycle the timeout expires, the data SHALL win and err=0.
REQ-026 The timeout counter SHALL saturate and SHALL be cleared on entry to WAIT_RD.

Reset
REQ-027 On rstB=0 at a clk edge, the fabric SHALL enter IDLE and clear the counter.
REQ-028 On reset, all mN_rdData, mN_rdValid, mN_err and the latched index/master SHALL be 0; s_wrEn and s_rdEn SHALL be 0 while in reset.
REQ-029 Reset during WAIT_RD SHALL abandon the read with no rdValid pulse.

Configuration
REQ-030 With BUS_TIMEOUT_EN defined, REQ-024..026 SHALL apply.
REQ-031 Without BUS_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely for outEn and no counter logic SHALL be instantiated.

Structure
REQ-032 Package periph_bus_pkg SHALL hold the state enum, BUS_ERR_DATA = 32'hDEAD_BEEF, and the default base/mask constants.
REQ-033 Sub-module periph_addr_decoder (combinational: addr -> hit, one-hot select, index) SHALL be instantiated once.

Verification
REQ-034 m0 write 0x55 to 0x404 -> s_wrEn=4'b0100 in the same cycle, s_wrData=0x55, no err.
REQ-035 m0 read 0x402, slave 1 outEn 3 cycles later with 0x41 -> m0_rdValid one cycle after outEn, rdData=0x41, err=0.
REQ-036 m0 and m1 both read in the same cycle -> m1_ready=1, m0_ready=0; m0 is served after m1's rdValid.
REQ-037 Read 0x7F0 (miss) -> next cycle rdValid=1, err=1, rdData=0; no s_rdEn.
REQ-038 Read slave 2 with no outEn, BUS_TIMEOUT_EN set -> after 15 cycles rdValid=1, err=1, rdData=0xDEADBEEF; without the macro, no response after 100 cycles.
REQ-039 rstB=0 asserted 2 cycles into WAIT_RD -> IDLE, no rdValid; a subsequent read completes normally.
